// File: rtl/vrf_pkg.sv
// Shared types and default sizing for the multi-port vector register file.
package vrf_pkg;

    localparam int VRF_NUM_REGS  = 32;
    localparam int VRF_NUM_LANES = 4;
    localparam int VRF_LANE_W    = 32;
    localparam int VRF_NUM_RD    = 2;

    typedef logic [VRF_LANE_W-1:0] lane_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } vrf_state_t;

endpackage

// File: rtl/vector_regfile_mp_if.sv
// Access bus of the vector register file: reads, writes, reservations and clear control.
interface vector_regfile_mp_if
    import vrf_pkg::*;
#(
    parameter int NUM_REGS  = VRF_NUM_REGS,
    parameter int NUM_LANES = VRF_NUM_LANES,
    parameter int LANE_W    = VRF_LANE_W,
    parameter int NUM_RD    = VRF_NUM_RD
);
    localparam int AW = $clog2(NUM_REGS);

    logic                 clear_req;
    logic                 ready;
    logic [AW-1:0]        rd_addr [NUM_RD];
    logic [LANE_W-1:0]    rd_data [NUM_RD][NUM_LANES];
    logic                 rd_busy [NUM_RD];
    logic [AW-1:0]        wr_addr;
    logic [LANE_W-1:0]    wr_data [NUM_LANES];
    logic [NUM_LANES-1:0] wr_en;
    logic                 rsv_valid;
    logic [AW-1:0]        rsv_addr;

    modport master (
        output clear_req, rd_addr, wr_addr, wr_data, wr_en, rsv_valid, rsv_addr,
        input  ready, rd_data, rd_busy
    );

    modport slave (
        input  clear_req, rd_addr, wr_addr, wr_data, wr_en, rsv_valid, rsv_addr,
        output ready, rd_data, rd_busy
    );

endinterface

// File: rtl/vrf_lane_bank.sv
// Storage for a single lane across all registers: one write port, NUM_RD asynchronous read ports.
module vrf_lane_bank
    import vrf_pkg::*;
#(
    parameter int NUM_REGS = VRF_NUM_REGS,
    parameter int LANE_W   = VRF_LANE_W,
    parameter int NUM_RD   = VRF_NUM_RD
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] waddr,
    input  logic [LANE_W-1:0]           wdata,
    input  logic [$clog2(NUM_REGS)-1:0] raddr [NUM_RD],
    output logic [LANE_W-1:0]           rdata [NUM_RD]
);

    // No reset on the array: contents are only ever zeroed by the clear sweep.
    logic [LANE_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rdata[p] = mem_q[raddr[p]];
        end
    end

endmodule

// File: rtl/vector_regfile_mp.sv
// Multi-port vector register file with per-lane write enables, write bypass,
// a busy scoreboard and a self-clearing sweep after reset or on request.
module vector_regfile_mp
    import vrf_pkg::*;
#(
    parameter int NUM_REGS  = VRF_NUM_REGS,
    parameter int NUM_LANES = VRF_NUM_LANES,
    parameter int LANE_W    = VRF_LANE_W,
    parameter int NUM_RD    = VRF_NUM_RD
) (
    input  logic                clk,
    input  logic                rst_n,
    vector_regfile_mp_if.slave  bus
);

    localparam int            AW       = $clog2(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    vrf_state_t           state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic [NUM_REGS-1:0]  busy_q, busy_d;

    logic                 sweep;
    logic                 accept;
    logic [NUM_LANES-1:0] bank_we;
    logic [AW-1:0]        bank_waddr;
    logic [LANE_W-1:0]    bank_wdata [NUM_LANES];
    logic [AW-1:0]        rd_addr_w  [NUM_RD];
    logic [LANE_W-1:0]    bank_rd    [NUM_LANES][NUM_RD];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (cnt_q == LAST_IDX) state_d = READY;
            READY:   if (bus.clear_req)     state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    // A clear request in READY swallows any write or reserve of the same cycle.
    always_comb begin
        sweep     = (state_q == CLEAR);
        bus.ready = (state_q == READY);
        accept    = bus.ready & ~bus.clear_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // Counter rests at zero in READY so every sweep starts from register 0.
    always_comb begin
        cnt_d = sweep ? cnt_q + 1'b1 : '0;
    end

    // Reserve is applied after the write-clear so it wins on an address collision.
    always_comb begin
        busy_d = busy_q;
        if (!accept) begin
            busy_d = '0;
        end else begin
            if (|bus.wr_en) busy_d[bus.wr_addr] = 1'b0;
            if (bus.rsv_valid) busy_d[bus.rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        bank_waddr = sweep ? cnt_q : bus.wr_addr;
        for (int l = 0; l < NUM_LANES; l++) begin
            bank_we[l]    = sweep | (accept & bus.wr_en[l]);
            bank_wdata[l] = sweep ? '0 : bus.wr_data[l];
        end
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr_w[p] = bus.rd_addr[p];
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        vrf_lane_bank #(
            .NUM_REGS (NUM_REGS),
            .LANE_W   (LANE_W),
            .NUM_RD   (NUM_RD)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[l]),
            .waddr (bank_waddr),
            .wdata (bank_wdata[l]),
            .raddr (rd_addr_w),
            .rdata (bank_rd[l])
        );
    end

    // Same-cycle lane writes bypass the array; everything reads zero while sweeping.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            bus.rd_busy[p] = bus.ready & busy_q[bus.rd_addr[p]];
            for (int l = 0; l < NUM_LANES; l++) begin
                bus.rd_data[p][l] = '0;
                if (bus.ready) begin
                    if (bus.wr_en[l] && (bus.wr_addr == bus.rd_addr[p])) begin
                        bus.rd_data[p][l] = bus.wr_data[l];
                    end else begin
                        bus.rd_data[p][l] = bank_rd[l][p];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_regfile_mp.sv
// Directed bench for vector_regfile_mp: sweep timing, partial writes, bypass, scoreboard, clear and reset.
module tb_vector_regfile_mp;
    import vrf_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   n;

    vector_regfile_mp_if bus ();

    vector_regfile_mp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clear_req = 1'b0;
        bus.wr_en     = '0;
        bus.wr_addr   = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_addr  = '0;
        for (int l = 0; l < 4; l++) bus.wr_data[l] = '0;
        for (int p = 0; p < 2; p++) bus.rd_addr[p] = '0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!bus.ready && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < 32; r++) begin
            bus.rd_addr[0] = 5'(r);
            bus.rd_addr[1] = 5'(31 - r);
            #1;
            for (int l = 0; l < 4; l++) begin
                check($sformatf("%s_p0_r%0d_l%0d", tag, r, l), bus.rd_data[0][l], 32'h0);
                check($sformatf("%s_p1_r%0d_l%0d", tag, 31 - r, l), bus.rd_data[1][l], 32'h0);
            end
            check($sformatf("%s_busy_r%0d", tag, r), {31'h0, bus.rd_busy[0]}, 32'h0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();

        // Reset held: not ready, outputs gated
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, bus.ready}, 32'h0);
        check("rst_busy0", {31'h0, bus.rd_busy[0]}, 32'h0);
        check("rst_data00", bus.rd_data[0][0], 32'h0);

        // Release: exactly 32 sweep cycles, then everything reads zero
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        check("sweep_len_reset", n, 32);
        check_all_zero("post_reset");

        // Partial write of reg 5
        bus.wr_addr    = 5'd5;
        bus.wr_data[0] = 32'hA;
        bus.wr_data[1] = 32'hB;
        bus.wr_data[2] = 32'hC;
        bus.wr_data[3] = 32'hD;
        bus.wr_en      = 4'b0101;
        tick();
        bus.wr_en      = 4'b0000;
        bus.rd_addr[0] = 5'd5;
        #1;
        check("pw_l0", bus.rd_data[0][0], 32'hA);
        check("pw_l1", bus.rd_data[0][1], 32'h0);
        check("pw_l2", bus.rd_data[0][2], 32'hC);
        check("pw_l3", bus.rd_data[0][3], 32'h0);

        // Bypass only for the enabled lane; other lanes come from storage
        bus.wr_data[0] = 32'h55;
        bus.wr_data[2] = 32'h77;
        bus.wr_en      = 4'b0001;
        #1;
        check("pbyp_l0", bus.rd_data[0][0], 32'h55);
        check("pbyp_l2", bus.rd_data[0][2], 32'hC);
        tick();
        bus.wr_en = 4'b0000;

        // Full bypass on both ports for reg 7
        bus.wr_addr    = 5'd7;
        for (int l = 0; l < 4; l++) bus.wr_data[l] = 32'h11223344;
        bus.wr_en      = 4'b1111;
        bus.rd_addr[0] = 5'd7;
        bus.rd_addr[1] = 5'd7;
        #1;
        for (int l = 0; l < 4; l++) begin
            check($sformatf("byp_p0_l%0d", l), bus.rd_data[0][l], 32'h11223344);
            check($sformatf("byp_p1_l%0d", l), bus.rd_data[1][l], 32'h11223344);
        end
        tick();
        bus.wr_en = 4'b0000;
        #1;
        check("byp_stored_l3", bus.rd_data[1][3], 32'h11223344);

        // Scoreboard: reserve, then write+reserve race, then write-only clear
        bus.rd_addr[0] = 5'd3;
        bus.rsv_valid  = 1'b1;
        bus.rsv_addr   = 5'd3;
        #1;
        check("sb_no_bypass", {31'h0, bus.rd_busy[0]}, 32'h0);
        tick();
        check("sb_reserved", {31'h0, bus.rd_busy[0]}, 32'h1);
        bus.wr_addr = 5'd3;
        bus.wr_en   = 4'b1111;
        tick();
        check("sb_race", {31'h0, bus.rd_busy[0]}, 32'h1);
        bus.rsv_valid = 1'b0;
        #1;
        check("sb_pre_clear", {31'h0, bus.rd_busy[0]}, 32'h1);
        tick();
        bus.wr_en = 4'b0000;
        #1;
        check("sb_cleared", {31'h0, bus.rd_busy[0]}, 32'h0);

        // Fill every register, reserve reg 9
        for (int r = 0; r < 32; r++) begin
            bus.wr_addr = 5'(r);
            for (int l = 0; l < 4; l++) bus.wr_data[l] = 32'h1000 + 32'(r * 4 + l);
            bus.wr_en = 4'b1111;
            tick();
        end
        bus.wr_en      = 4'b0000;
        bus.rd_addr[0] = 5'd20;
        #1;
        check("fill_r20_l1", bus.rd_data[0][1], 32'h1051);
        bus.rsv_valid  = 1'b1;
        bus.rsv_addr   = 5'd9;
        tick();
        bus.rsv_valid  = 1'b0;
        bus.rd_addr[1] = 5'd9;
        #1;
        check("busy9_set", {31'h0, bus.rd_busy[1]}, 32'h1);

        // Clear together with a write to reg 2; stray requests during the sweep are ignored
        bus.clear_req = 1'b1;
        bus.wr_addr   = 5'd2;
        for (int l = 0; l < 4; l++) bus.wr_data[l] = 32'hDEAD;
        bus.wr_en     = 4'b1111;
        tick();
        idle_inputs();
        bus.rd_addr[1] = 5'd9;
        n = 0;
        while (!bus.ready && n < 40) begin
            if (n == 5) begin
                check("clr_gated_data", bus.rd_data[1][0], 32'h0);
                check("clr_gated_busy", {31'h0, bus.rd_busy[1]}, 32'h0);
            end
            bus.clear_req = (n == 10);
            if (n == 20) begin
                bus.wr_addr   = 5'd0;
                bus.wr_en     = 4'b1111;
                bus.rsv_valid = 1'b1;
                bus.rsv_addr  = 5'd9;
                for (int l = 0; l < 4; l++) bus.wr_data[l] = 32'hFFFF;
            end else begin
                bus.wr_en     = 4'b0000;
                bus.rsv_valid = 1'b0;
            end
            tick();
            n++;
        end
        idle_inputs();
        check("sweep_len_clear", n, 32);
        check_all_zero("post_clear");

        // Reset at sweep index 17 restarts a full sweep
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        repeat (17) tick();
        check("mid_sweep_ready", {31'h0, bus.ready}, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'h0, bus.ready}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        check("sweep_len_midrst", n, 32);
        check_all_zero("post_midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
